calc_multi_port: RTL
====================

Name: calc_multi_port

Overview:
- Parametrised successor of the single-request calc1 datapath: NUM_PORTS independent request ports share one registered ALU.
- Each port accepts two-cycle command/operand transactions, tags them, and queues them in a per-port FIFO.
- A round-robin arbiter issues one queued operation per cycle to the ALU. The result returns on the originating port with its tag.
- Sits between the request generators and the result-consumer blocks in the calc subsystem.

Parameters:
NUM_PORTS, 4, number of request/response ports (1..8)
DATA_W, 32, operand/result width
CMD_W, 4, command field width
TAG_W, 2, tag width echoed with each response
QDEPTH, 4, per-port FIFO depth (power of two, >=2)

Ports:
c_clk  input  1  single clock, rising edge
reset_n  input  1  asynchronous active-low reset
req_cmd_in  input  NUM_PORTS*CMD_W  per-port command; port p at [p*CMD_W +: CMD_W]
req_data_in  input  NUM_PORTS*DATA_W  per-port operand bus
req_tag_in  input  NUM_PORTS*TAG_W  per-port tag, sampled with command
req_ready  output  NUM_PORTS  port may start a new command this cycle
out_resp  output  NUM_PORTS*2  response code, valid for one cycle
out_data  output  NUM_PORTS*DATA_W  result data
out_tag  output  NUM_PORTS*TAG_W  echoed tag

Behaviour:
- Reset (async assert, sync deassert via c_clk):
  - All outputs 0; req_ready all 0 while reset_n is low, all 1 on the first cycle after.
  - FIFOs empty, capture FSMs IDLE, RR pointer 0.
  - Reset mid-transaction discards all captured and queued work; no response is emitted for it.
- Commands: 0 NOP, 1 ADD, 2 SUB, 5 SHL, 6 SHR; every other nonzero value is invalid.
- Responses: 0 none, 1 success, 2 overflow/underflow, 3 invalid command.
- Per-port capture FSM:
  - IDLE: on edge with cmd!=0 and req_ready=1, latch cmd, tag and data as op1 -> OP2. cmd!=0 while req_ready=0 is dropped silently.
  - OP2: next edge latches data as op2 (cmd ignored), pushes {cmd,tag,op1,op2} into the port FIFO -> IDLE. Back-to-back commands are allowed.
- req_ready[p] = (fifo_count + in-flight capture) < QDEPTH. The FIFO slot is reserved at the IDLE->OP2 edge, so the OP2 push never overflows.
- Invalid commands are queued like valid ones and answered with resp 3 and data 0.
- Arbiter:
  - Each cycle, grant the first non-empty FIFO at or after the RR pointer and pop it into the ALU register; pointer <= granted+1 (mod NUM_PORTS).
  - If no FIFO is non-empty, nothing is granted and the pointer holds.
  - A push and a pop on the same FIFO in the same cycle are legal; count is unchanged.
- ALU (registered, one stage):
  - ADD: unsigned; carry out -> resp 2, data 0.
  - SUB: op2>op1 -> resp 2, data 0; op1==op2 -> resp 1, data 0.
  - SHL/SHR: logical shift of op1 by op2[$clog2(DATA_W)-1:0]; upper op2 bits ignored; always resp 1.
- Output: the ALU result is registered into the granted port's out_resp/out_data/out_tag for exactly one cycle, then returns to 0.
- Latency: op2 sampled on edge E; entry granted on E+1; response visible after E+2. Uncontended latency is 2 clocks after op2; each contending port ahead in RR order adds 1 clock.
- Ordering: in-order within a port; unordered across ports. At most one port responds per cycle.

Decomposition:
- Package calc_pkg: command codes, response codes, the queue-entry struct {cmd, tag, op1, op2}, shift-amount width function.
- Sub-module calc_port_fifo: parametrised sync FIFO with count output, instantiated NUM_PORTS times.
- Capture FSM, arbiter and ALU stay in the top module.

Test Plan:
- Port0 ADD op1=1, op2=2, tag=1 -> port0 resp 1, data 3, tag 1, exactly 2 clocks after op2 cycle; other ports silent.
- ADD 0xFFFF_FFFF+1 -> resp 2, data 0; SUB 5-7 -> resp 2, data 0; SHL 1 by 35 -> resp 1, data 8; cmd 3 -> resp 3, data 0.
- All 4 ports issue ADD in the same cycle (tags 0..3) -> responses on ports 0,1,2,3 in consecutive cycles at latency 2,3,4,5; second identical burst is served in the same RR order starting at port 0.
- Port2 issues 5 back-to-back commands with QDEPTH=4 while arbiter is busy -> req_ready[2] drops after the 4th reservation; 5th command dropped; 4 in-order responses with tags 0..3.
- Assert reset_n low during port1 OP2 with 2 entries queued -> all outputs 0 immediately; no responses after release; next command answered normally.

Source files
------------

// File: rtl/calc_pkg.sv
// Shared encodings and helpers for the calc_multi_port datapath.
package calc_pkg;

    localparam int unsigned CMD_NOP = 0;
    localparam int unsigned CMD_ADD = 1;
    localparam int unsigned CMD_SUB = 2;
    localparam int unsigned CMD_SHL = 5;
    localparam int unsigned CMD_SHR = 6;

    localparam logic [1:0] RESP_NONE = 2'd0;
    localparam logic [1:0] RESP_OK   = 2'd1;
    localparam logic [1:0] RESP_OVF  = 2'd2;
    localparam logic [1:0] RESP_INV  = 2'd3;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_OP2  = 1'b1;

    function automatic int unsigned shamt_w(input int unsigned data_w);
        return (data_w > 1) ? $clog2(data_w) : 1;
    endfunction

endpackage

// File: rtl/calc_port_fifo.sv
// Synchronous FIFO with occupancy count; one instance per request port.
module calc_port_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push,
    input  logic [WIDTH-1:0]       push_data,
    input  logic                   pop,
    output logic [WIDTH-1:0]       pop_data,
    output logic [$clog2(DEPTH):0] count,
    output logic                   empty
);
    import calc_pkg::*;

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;

    assign pop_data = mem[rd_ptr];
    assign empty    = (count == '0);

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/calc_multi_port.sv
// Multi-port calc datapath: per-port two-cycle capture into FIFOs,
// round-robin issue into one registered ALU, result returned on the source port.
module calc_multi_port #(
    parameter int NUM_PORTS = 4,
    parameter int DATA_W    = 32,
    parameter int CMD_W     = 4,
    parameter int TAG_W     = 2,
    parameter int QDEPTH    = 4
) (
    input  logic                        c_clk,
    input  logic                        reset_n,
    input  logic [NUM_PORTS*CMD_W-1:0]  req_cmd_in,
    input  logic [NUM_PORTS*DATA_W-1:0] req_data_in,
    input  logic [NUM_PORTS*TAG_W-1:0]  req_tag_in,
    output logic [NUM_PORTS-1:0]        req_ready,
    output logic [NUM_PORTS*2-1:0]      out_resp,
    output logic [NUM_PORTS*DATA_W-1:0] out_data,
    output logic [NUM_PORTS*TAG_W-1:0]  out_tag
);
    import calc_pkg::*;

    localparam int SHW   = int'(shamt_w(DATA_W));
    localparam int CNT_W = $clog2(QDEPTH) + 1;
    localparam int PTR_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
    localparam logic [CNT_W:0] QD = (CNT_W+1)'(QDEPTH);

    typedef struct packed {
        logic [CMD_W-1:0]  cmd;
        logic [TAG_W-1:0]  tag;
        logic [DATA_W-1:0] op1;
        logic [DATA_W-1:0] op2;
    } entry_t;

    localparam int ENTRY_W = $bits(entry_t);

    logic [0:0]        st      [NUM_PORTS];
    logic [CMD_W-1:0]  cap_cmd [NUM_PORTS];
    logic [TAG_W-1:0]  cap_tag [NUM_PORTS];
    logic [DATA_W-1:0] cap_op1 [NUM_PORTS];

    logic [NUM_PORTS-1:0] push;
    logic [NUM_PORTS-1:0] pop;
    logic [NUM_PORTS-1:0] empty;
    entry_t               push_data [NUM_PORTS];
    entry_t               head      [NUM_PORTS];
    logic [CNT_W-1:0]     count     [NUM_PORTS];

    logic [PTR_W-1:0]  rr_ptr;
    logic [PTR_W-1:0]  grant_idx;
    logic [PTR_W-1:0]  cand;
    logic              grant_vld;
    entry_t            sel;
    logic [DATA_W:0]   sum;
    logic [SHW-1:0]    shamt;
    logic [1:0]        res_resp;
    logic [DATA_W-1:0] res_data;

    logic              alu_vld;
    logic [PTR_W-1:0]  alu_port;
    logic [1:0]        alu_resp;
    logic [DATA_W-1:0] alu_data;
    logic [TAG_W-1:0]  alu_tag;

    // A capture in OP2 already owns a FIFO slot, so its push can never overflow.
    always_comb begin
        req_ready = '0;
        push      = '0;
        push_data = '{default: '0};
        for (int unsigned p = 0; p < NUM_PORTS; p++) begin
            req_ready[p] = reset_n &&
                (({1'b0, count[p]} + (CNT_W+1)'(st[p] == ST_OP2)) < QD);
            push[p]      = (st[p] == ST_OP2);
            push_data[p] = '{cmd: cap_cmd[p], tag: cap_tag[p], op1: cap_op1[p],
                             op2: req_data_in[p*DATA_W +: DATA_W]};
        end
    end

    always_ff @(posedge c_clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int unsigned p = 0; p < NUM_PORTS; p++) begin
                st[p]      <= ST_IDLE;
                cap_cmd[p] <= '0;
                cap_tag[p] <= '0;
                cap_op1[p] <= '0;
            end
        end else begin
            for (int unsigned p = 0; p < NUM_PORTS; p++) begin
                if (st[p] == ST_OP2) begin
                    st[p] <= ST_IDLE;
                end else if (req_cmd_in[p*CMD_W +: CMD_W] != CMD_W'(CMD_NOP) && req_ready[p]) begin
                    st[p]      <= ST_OP2;
                    cap_cmd[p] <= req_cmd_in[p*CMD_W +: CMD_W];
                    cap_tag[p] <= req_tag_in[p*TAG_W +: TAG_W];
                    cap_op1[p] <= req_data_in[p*DATA_W +: DATA_W];
                end
            end
        end
    end

    for (genvar g = 0; g < NUM_PORTS; g++) begin : g_fifo
        calc_port_fifo #(
            .WIDTH (ENTRY_W),
            .DEPTH (QDEPTH)
        ) u_fifo (
            .clk       (c_clk),
            .rst_n     (reset_n),
            .push      (push[g]),
            .push_data (push_data[g]),
            .pop       (pop[g]),
            .pop_data  (head[g]),
            .count     (count[g]),
            .empty     (empty[g])
        );
    end

    always_comb begin
        grant_vld = 1'b0;
        grant_idx = '0;
        cand      = '0;
        for (int unsigned i = 0; i < NUM_PORTS; i++) begin
            cand = PTR_W'((32'(rr_ptr) + i) % 32'(NUM_PORTS));
            if (!grant_vld && !empty[cand]) begin
                grant_vld = 1'b1;
                grant_idx = cand;
            end
        end
        pop            = '0;
        pop[grant_idx] = grant_vld;
    end

    always_comb begin
        sel      = head[grant_idx];
        sum      = {1'b0, sel.op1} + {1'b0, sel.op2};
        shamt    = sel.op2[SHW-1:0];
        res_resp = RESP_OK;
        res_data = '0;
        case (sel.cmd)
            CMD_W'(CMD_ADD): begin
                if (sum[DATA_W]) res_resp = RESP_OVF;
                else             res_data = sum[DATA_W-1:0];
            end
            CMD_W'(CMD_SUB): begin
                if (sel.op2 > sel.op1) res_resp = RESP_OVF;
                else                   res_data = sel.op1 - sel.op2;
            end
            CMD_W'(CMD_SHL): res_data = sel.op1 << shamt;
            CMD_W'(CMD_SHR): res_data = sel.op1 >> shamt;
            default:         res_resp = RESP_INV;
        endcase
    end

    always_ff @(posedge c_clk or negedge reset_n) begin
        if (!reset_n) begin
            rr_ptr   <= '0;
            alu_vld  <= 1'b0;
            alu_port <= '0;
            alu_resp <= RESP_NONE;
            alu_data <= '0;
            alu_tag  <= '0;
        end else begin
            alu_vld <= grant_vld;
            if (grant_vld) begin
                alu_port <= grant_idx;
                alu_resp <= res_resp;
                alu_data <= res_data;
                alu_tag  <= sel.tag;
                rr_ptr   <= PTR_W'((32'(grant_idx) + 1) % 32'(NUM_PORTS));
            end
        end
    end

    always_ff @(posedge c_clk or negedge reset_n) begin
        if (!reset_n) begin
            out_resp <= '0;
            out_data <= '0;
            out_tag  <= '0;
        end else begin
            for (int unsigned p = 0; p < NUM_PORTS; p++) begin
                out_resp[p*2 +: 2] <= (alu_vld && 32'(alu_port) == p) ? alu_resp : RESP_NONE;
                out_data[p*DATA_W +: DATA_W] <= (alu_vld && 32'(alu_port) == p) ? alu_data : '0;
                out_tag[p*TAG_W +: TAG_W]    <= (alu_vld && 32'(alu_port) == p) ? alu_tag : '0;
            end
        end
    end

endmodule
